// File: rtl/rk4_stage_sequencer.sv
// rk4_stage_sequencer
// Sequences the four RK4 stage evaluations (k1..k4) of each integration step
// through one shared derivative unit, then commits the weighted state update.
// Repeats for a latched number of steps.
// Optional stall watchdog: define RK4_SEQ_STALL_WATCHDOG_EN to build it;
// otherwise stall is tied low.
module rk4_stage_sequencer #(
  parameter int CNT_W       = 32,
  parameter int STALL_W     = 16,
  parameter int STALL_LIMIT = 1000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] n_steps,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] step_count,
  output logic             eval_valid,
  input  logic             eval_ready,
  output logic [1:0]       eval_stage,
  output logic [1:0]       eval_hscale,
  input  logic             res_valid,
  output logic             acc_en,
  output logic             acc_weight,
  output logic             state_commit,
  output logic             stall
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_COMMIT = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  state_t           state_reg, state_next;
  logic [1:0]       stage_reg, stage_next;
  logic [CNT_W-1:0] step_count_reg, step_count_next;
  logic [CNT_W-1:0] n_steps_reg, n_steps_next;
  logic             zero_done_reg, zero_done_next;
  logic [CNT_W-1:0] step_inc;
  logic             start_accept;
  logic             done_fsm;

  // A start is only taken in IDLE, and an abort in the same cycle drops it.
  assign start_accept = (state_reg == ST_IDLE) && start && !abort;

  // Saturating increment; unreachable in practice while n_steps fits CNT_W.
  assign step_inc = (step_count_reg == {CNT_W{1'b1}}) ? step_count_reg
                                                      : step_count_reg + 1'b1;

  // State and datapath registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      stage_reg      <= 2'd0;
      step_count_reg <= '0;
      n_steps_reg    <= '0;
      zero_done_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      stage_reg      <= stage_next;
      step_count_reg <= step_count_next;
      n_steps_reg    <= n_steps_next;
      zero_done_reg  <= zero_done_next;
    end
  end

  // Next-state logic and handshake/strobe outputs; abort overrides everything.
  always_comb begin
    state_next      = state_reg;
    stage_next      = stage_reg;
    step_count_next = step_count_reg;
    n_steps_next    = n_steps_reg;
    zero_done_next  = 1'b0;
    eval_valid      = 1'b0;
    acc_en          = 1'b0;
    state_commit    = 1'b0;
    done_fsm        = 1'b0;

    if (abort && (state_reg != ST_IDLE)) begin
      // Withdraws eval_valid and suppresses every strobe this cycle.
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start_accept) begin
            step_count_next = '0;
            stage_next      = 2'd0;
            if (n_steps != '0) begin
              n_steps_next = n_steps;
              state_next   = ST_ISSUE;
            end else begin
              // Empty run: report completion without leaving IDLE.
              zero_done_next = 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          eval_valid = 1'b1;
          if (eval_ready) begin
            state_next = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (res_valid) begin
            acc_en = 1'b1;
            if (stage_reg != 2'd3) begin
              stage_next = stage_reg + 2'd1;
              state_next = ST_ISSUE;
            end else begin
              state_next = ST_COMMIT;
            end
          end
        end
        ST_COMMIT: begin
          state_commit    = 1'b1;
          step_count_next = step_inc;
          if (step_inc == n_steps_reg) begin
            state_next = ST_DONE;
          end else begin
            stage_next = 2'd0;
            state_next = ST_ISSUE;
          end
        end
        ST_DONE: begin
          done_fsm   = 1'b1;
          state_next = ST_IDLE;
        end
        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  // Input offset for each stage: k1 at x_n, k2/k3 at half step, k4 at full step.
  always_comb begin
    eval_hscale = 2'd0;
    case (stage_reg)
      2'd0:    eval_hscale = 2'd0;
      2'd1:    eval_hscale = 2'd1;
      2'd2:    eval_hscale = 2'd1;
      default: eval_hscale = 2'd2;
    endcase
  end

  assign busy       = (state_reg != ST_IDLE);
  assign done       = done_fsm | zero_done_reg;
  assign step_count = step_count_reg;
  assign eval_stage = stage_reg;
  // k2 and k3 carry double weight in the RK4 sum.
  assign acc_weight = (stage_reg == 2'd1) || (stage_reg == 2'd2);

`ifdef RK4_SEQ_STALL_WATCHDOG_EN
  localparam logic [STALL_W-1:0] LIMIT = STALL_W'(STALL_LIMIT);

  logic [STALL_W-1:0] stall_cnt_reg, stall_cnt_next;
  logic               stall_reg, stall_next;
  logic               stalled;

  // Stalled means waiting on the derivative unit: no accept or no result.
  assign stalled = ((state_reg == ST_ISSUE) && !eval_ready) ||
                   ((state_reg == ST_WAIT)  && !res_valid);

  // Consecutive-stall counter (held at the limit) and sticky flag.
  always_comb begin
    stall_cnt_next = '0;
    stall_next     = stall_reg;
    if (stalled) begin
      stall_cnt_next = (stall_cnt_reg >= LIMIT) ? stall_cnt_reg
                                                : stall_cnt_reg + 1'b1;
    end
    if (stall_cnt_next >= LIMIT) begin
      stall_next = 1'b1;
    end
    if (start_accept) begin
      stall_next = 1'b0;
    end
  end

  // Watchdog registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cnt_reg <= '0;
      stall_reg     <= 1'b0;
    end else begin
      stall_cnt_reg <= stall_cnt_next;
      stall_reg     <= stall_next;
    end
  end

  assign stall = stall_reg;
`else
  assign stall = 1'b0;
`endif

endmodule

// File: tb/tb_rk4_stage_sequencer.sv
// Scoreboard bench for rk4_stage_sequencer: stimulus queues expected events
// (handshake, accumulate, commit, done) with their expected cycle; a monitor
// compares them as the DUT produces them.
module tb_rk4_stage_sequencer;

  localparam int CNT_W = 32;

  localparam int EV_HS   = 0;
  localparam int EV_ACC  = 1;
  localparam int EV_CMT  = 2;
  localparam int EV_DONE = 3;

  logic             clock;
  logic             reset;
  logic             start;
  logic [CNT_W-1:0] n_steps;
  logic             abort;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] step_count;
  logic             eval_valid;
  logic             eval_ready;
  logic [1:0]       eval_stage;
  logic [1:0]       eval_hscale;
  logic             res_valid;
  logic             acc_en;
  logic             acc_weight;
  logic             state_commit;
  logic             stall;

  logic res_pulse;
  logic res_force;
  logic auto_res;

  assign res_valid = res_pulse | res_force;

  rk4_stage_sequencer #(
    .CNT_W(CNT_W),
    .STALL_W(16),
    .STALL_LIMIT(8)
  ) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .n_steps(n_steps),
    .abort(abort),
    .busy(busy),
    .done(done),
    .step_count(step_count),
    .eval_valid(eval_valid),
    .eval_ready(eval_ready),
    .eval_stage(eval_stage),
    .eval_hscale(eval_hscale),
    .res_valid(res_valid),
    .acc_en(acc_en),
    .acc_weight(acc_weight),
    .state_commit(state_commit),
    .stall(stall)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int kind;
    int data;
    int cyc;
  } ev_t;

  ev_t exp_q[$];
  int  total = 0;
  int  bad   = 0;
  int  cyc   = 0;

  // Hand-computed stage tables: hscale and accumulate weight for k1..k4.
  int hs_tab [4] = '{0, 1, 1, 2};
  int w_tab  [4] = '{0, 1, 1, 0};

`ifdef RK4_SEQ_STALL_WATCHDOG_EN
  localparam int EXP_WD = 1;
`else
  localparam int EXP_WD = 0;
`endif

  // Cycle counter: value during the cycle that follows posedge number cyc.
  initial forever begin
    @(posedge clock);
    cyc++;
  end

  // Derivative-unit model: result one cycle after each handshake.
  initial begin
    logic hs;
    res_pulse = 1'b0;
    forever begin
      @(negedge clock);
      hs = eval_valid && eval_ready;
      @(posedge clock);
      #1;
      res_pulse = hs && auto_res;
    end
  end

  task automatic push(input int kind, input int data, input int c);
    ev_t e;
    e.kind = kind;
    e.data = data;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  // Expected events for a run of n steps started in cycle s, no backpressure.
  task automatic push_run(input int s, input int n);
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < 4; j++) begin
        push(EV_HS, j * 4 + hs_tab[j], s + 1 + 9 * i + 2 * j);
        push(EV_ACC, w_tab[j], s + 2 + 9 * i + 2 * j);
      end
      push(EV_CMT, i, s + 9 + 9 * i);
    end
    push(EV_DONE, n, s + 9 * n + 1);
  endtask

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end else begin
      $display("ok   %s = %0d (cycle %0d)", name, act, cyc);
    end
  endtask

  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Pulse start for one cycle; returns the cycle in which start was high.
  task automatic do_start(input int n, output int s);
    s       = cyc;
    start   = 1'b1;
    n_steps = CNT_W'(n);
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  function automatic string kname(input int k);
    case (k)
      EV_HS:   return "handshake";
      EV_ACC:  return "acc";
      EV_CMT:  return "commit";
      default: return "done";
    endcase
  endfunction

  task automatic observe(input int kind, input int data);
    ev_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL unexpected %s: got data=%0d at cycle %0d, expected no event",
               kname(kind), data, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.data != data || e.cyc != cyc) begin
        bad++;
        $display("FAIL event: got %s data=%0d cycle=%0d expected %s data=%0d cycle=%0d",
                 kname(kind), data, cyc, kname(e.kind), e.data, e.cyc);
      end else begin
        $display("ok   %s data=%0d cycle=%0d", kname(kind), data, cyc);
      end
    end
  endtask

  // Monitor: compare every DUT event against the scoreboard, mid-cycle.
  initial forever begin
    @(negedge clock);
    if (!reset) begin
      if (eval_valid && eval_ready) observe(EV_HS, int'(eval_stage) * 4 + int'(eval_hscale));
      if (acc_en)                   observe(EV_ACC, int'(acc_weight));
      if (state_commit)             observe(EV_CMT, int'(step_count));
      if (done)                     observe(EV_DONE, int'(step_count));
    end
  end

  initial begin
    int s;
    int s2;
    reset      = 1'b1;
    start      = 1'b0;
    n_steps    = '0;
    abort      = 1'b0;
    eval_ready = 1'b1;
    res_force  = 1'b0;
    auto_res   = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;

    // Reset state
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_eval_valid", int'(eval_valid), 0);
    chk("rst_acc_en", int'(acc_en), 0);
    chk("rst_commit", int'(state_commit), 0);
    chk("rst_stall", int'(stall), 0);
    chk("rst_step_count", int'(step_count), 0);
    chk("rst_stage", int'(eval_stage), 0);
    chk("rst_hscale", int'(eval_hscale), 0);
    chk("rst_weight", int'(acc_weight), 0);

    // Basic run, 3 steps: done 28 cycles after start
    goto(cyc + 2);
    push_run(cyc, 3);
    do_start(3, s);
    chk("basic_busy", int'(busy), 1);
    goto(s + 29);
    chk("basic_step_count", int'(step_count), 3);
    chk("basic_idle", int'(busy), 0);

    // Zero steps: done next cycle, never busy
    goto(cyc + 2);
    push(EV_DONE, 0, cyc + 1);
    do_start(0, s);
    chk("zero_busy", int'(busy), 0);
    chk("zero_eval_valid", int'(eval_valid), 0);
    goto(s + 2);
    chk("zero_busy2", int'(busy), 0);
    chk("zero_eval_valid2", int'(eval_valid), 0);

    // Backpressure in stage 2 plus a stray res_valid during ISSUE
    goto(cyc + 2);
    s = cyc;
    push(EV_HS, 0, s + 1);  push(EV_ACC, 0, s + 2);
    push(EV_HS, 5, s + 3);  push(EV_ACC, 1, s + 4);
    push(EV_HS, 9, s + 10); push(EV_ACC, 1, s + 11);
    push(EV_HS, 14, s + 12); push(EV_ACC, 0, s + 13);
    push(EV_CMT, 0, s + 14);
    push(EV_DONE, 1, s + 15);
    do_start(1, s);
    goto(s + 5);
    eval_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k == 2) res_force = 1'b1;
      else        res_force = 1'b0;
      chk("bp_valid_held", int'(eval_valid), 1);
      chk("bp_stage_held", int'(eval_stage), 2);
      @(posedge clock);
      #1;
    end
    res_force  = 1'b0;
    eval_ready = 1'b1;
    goto(s + 17);
    chk("bp_step_count", int'(step_count), 1);

    // Abort during WAIT of stage 1 of step 2
    goto(cyc + 2);
    s = cyc;
    for (int j = 0; j < 4; j++) begin
      push(EV_HS, j * 4 + hs_tab[j], s + 1 + 2 * j);
      push(EV_ACC, w_tab[j], s + 2 + 2 * j);
    end
    push(EV_CMT, 0, s + 9);
    push(EV_HS, 0, s + 10); push(EV_ACC, 0, s + 11);
    push(EV_HS, 5, s + 12);
    do_start(4, s);
    goto(s + 13);
    abort = 1'b1;
    @(posedge clock);
    #1;
    abort = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_step_count", int'(step_count), 1);
    goto(s + 20);
    chk("abort_still_idle", int'(busy), 0);

    // Start while busy is ignored; restart clears step_count
    goto(cyc + 2);
    push_run(cyc, 1);
    do_start(1, s);
    goto(s + 4);
    start   = 1'b1;
    n_steps = CNT_W'(7);
    @(posedge clock);
    #1;
    start   = 1'b0;
    n_steps = CNT_W'(1);
    goto(s + 11);
    chk("ignored_start_count", int'(step_count), 1);
    push_run(cyc, 2);
    do_start(2, s2);
    chk("restart_clear", int'(step_count), 0);
    goto(s2 + 20);
    chk("restart_count", int'(step_count), 2);

    // Result withheld: watchdog behaviour (flag stays 0 when not built)
    goto(cyc + 2);
    s = cyc;
    auto_res = 1'b0;
    push(EV_HS, 0, s + 1);
    push(EV_ACC, 0, s + 12);
    push(EV_HS, 5, s + 13);  push(EV_ACC, 1, s + 14);
    push(EV_HS, 9, s + 15);  push(EV_ACC, 1, s + 16);
    push(EV_HS, 14, s + 17); push(EV_ACC, 0, s + 18);
    push(EV_CMT, 0, s + 19);
    push(EV_DONE, 1, s + 20);
    do_start(1, s);
    goto(s + 9);
    chk("wd_before_limit", int'(stall), 0);
    goto(s + 10);
    chk("wd_at_limit", int'(stall), EXP_WD);
    goto(s + 12);
    res_force = 1'b1;
    auto_res  = 1'b1;
    @(posedge clock);
    #1;
    res_force = 1'b0;
    goto(s + 21);
    chk("wd_sticky", int'(stall), EXP_WD);
    push(EV_DONE, 0, cyc + 1);
    do_start(0, s2);
    chk("wd_cleared", int'(stall), 0);

    goto(cyc + 4);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
